ddr2_axi_req_queue: RTL and testbench
=====================================

DDR2_AXI_REQ_QUEUE -- requirements
Module: ddr2_axi_req_queue

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_WIDTH, 28, AXI/DDR2 byte address width
- DATA_WIDTH, 32, data width
- AXI_ID_WIDTH, 4, ID width
- DEPTH, 4, max outstanding requests; power of 2, at least 2
REQ-002 Clocking: one clock; reset is asynchronous and active-low. Ports SHALL be (name, direction, width, meaning):
- ACLK, in, 1, clock
- ARESETN, in, 1, async active-low reset
REQ-003 AXI slave ports (direction, width):
- S_AXI_AWID in AXI_ID_WIDTH; S_AXI_AWADDR in ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA in DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BID out AXI_ID_WIDTH; S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARID in AXI_ID_WIDTH; S_AXI_ARADDR in ADDR_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RID out AXI_ID_WIDTH; S_AXI_RDATA out DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
REQ-004 Controller-side ports (direction, width):
- cmd_valid out 1; cmd_ready in 1
- cmd_write out 1; cmd_addr out ADDR_WIDTH; cmd_wdata out DATA_WIDTH; cmd_wstrb out DATA_WIDTH/8
- cpl_valid in 1; cpl_ready out 1; cpl_rdata in DATA_WIDTH; cpl_error in 1

Function
REQ-005 Write request SHALL be accepted only when AWVALID and WVALID are both high in the same cycle; AWREADY and WREADY SHALL always be equal.
REQ-006 Accept condition: outstanding count < DEPTH and the request is granted by arbitration.
REQ-007 Arbitration when a write pair and ARVALID are both present: alternate, granting the type not granted last. After reset, write is favoured. A lone request is granted whenever outstanding count < DEPTH.
REQ-008 At most one request SHALL be accepted per cycle. READY outputs SHALL be combinational from the grant.
REQ-009 Each accepted request SHALL be pushed into a DEPTH-entry command FIFO holding {write, addr, wdata, wstrb}. For reads, wdata and wstrb SHALL be zero.
REQ-010 Each accepted request SHALL also be pushed into a DEPTH-entry order FIFO holding {write, id}.
REQ-011 cmd_valid SHALL equal "command FIFO not empty", with cmd_* showing the head entry. The head SHALL pop on cmd_valid && cmd_ready. Latency from acceptance to cmd_valid: 1 cycle.
REQ-012 Outstanding count SHALL be incremented on accept and decremented on completion handshake (cpl_valid && cpl_ready). Both in one cycle: count unchanged. Range: 0..DEPTH.
REQ-013 Completions SHALL be taken as in-order. A completion handshake SHALL pop the order FIFO head.
- Write head: load BID=id, BRESP, set BVALID.
- Read head: load RID=id, RDATA=cpl_rdata, RRESP, set RVALID.
REQ-014 RESP SHALL be 2'b10 if cpl_error, else 2'b00.
REQ-015 cpl_ready = !S_AXI_BVALID && !S_AXI_RVALID.
REQ-016 BVALID SHALL clear on BREADY. RVALID SHALL clear on RREADY. Response signals SHALL be held stable while VALID is high.
REQ-017 A completion with the order FIFO empty SHALL be ignored: cpl_ready=1, no state change.
REQ-018 FIFO pointers SHALL use log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty SHALL be derived from the MSB and the remaining pointer bits.
REQ-019 Accept and pop in the same cycle SHALL be legal for both FIFOs at any fill level, including full and empty.

Reset
REQ-020 While ARESETN=0:
- all READY, cmd_valid, BVALID, RVALID = 0
- BRESP, RRESP, BID, RID, RDATA = 0
- FIFOs empty, outstanding count = 0, arbitration = write-favoured
REQ-021 Reset mid-operation SHALL discard all queued and outstanding requests without emitting responses. The first cycle after deassertion SHALL behave as idle.

Verification
REQ-022 Single write: AWADDR=0x0001000, WDATA=0xA5A5_1234, WSTRB=0xF, AWID=3 -> cmd_valid next cycle with cmd_write=1 and those values. After cpl (error=0): BVALID with BID=3, BRESP=0.
REQ-023 Simultaneous write (ID 1) and read (ID 2) held for 2 cycles -> write granted first, read second. cmd order W,R. Responses: B(ID1), then R(ID2, RDATA=cpl_rdata=0xDEAD_BEEF).
REQ-024 Issue 4 reads with cmd_ready=0 -> ARREADY drops after 4th. Fifth accepted only in the cycle after the first completion handshake.
REQ-025 Completion with cpl_error=1 on a read -> RRESP=2'b10. RREADY held 0 for 3 cycles -> cpl_ready=0 and RDATA stable throughout.
REQ-026 Assert ARESETN=0 with 3 outstanding and BVALID=1 -> all outputs zero immediately. After release, a new write completes normally with correct BID.

Source files
------------

// File: rtl/ddr2_axi_req_queue_if.sv
//------------------------------------------------------------------------------
// ddr2_axi_req_queue_if : AXI slave and controller command/completion bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ddr2_axi_req_queue_if #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 32,
  parameter int AXI_ID_WIDTH = 4
);
  logic [AXI_ID_WIDTH-1:0]   S_AXI_AWID;
  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [AXI_ID_WIDTH-1:0]   S_AXI_BID;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [AXI_ID_WIDTH-1:0]   S_AXI_ARID;
  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [AXI_ID_WIDTH-1:0]   S_AXI_RID;
  logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_wstrb;
  logic                      cpl_valid;
  logic                      cpl_ready;
  logic [DATA_WIDTH-1:0]     cpl_rdata;
  logic                      cpl_error;

  // Queue side: AXI slave towards the host, command master towards the controller
  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cpl_ready,
    input  cmd_ready, cpl_valid, cpl_rdata, cpl_error
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cpl_ready,
    output cmd_ready, cpl_valid, cpl_rdata, cpl_error
  );
endinterface

`default_nettype wire

// File: rtl/ddr2_axi_req_queue.sv
//------------------------------------------------------------------------------
// ddr2_axi_req_queue : AXI request arbiter with command FIFO and in-order completion
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr2_axi_req_queue #(
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  wire logic           ACLK,
  input  wire logic           ARESETN,
  ddr2_axi_req_queue_if.slave bus
);

  localparam int unsigned C_IDX_W  = $clog2(DEPTH);
  localparam int unsigned C_PTR_W  = C_IDX_W + 1;
  localparam int unsigned C_STRB_W = DATA_WIDTH / 8;
  localparam int unsigned C_CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH + C_STRB_W;
  localparam int unsigned C_ORD_W  = 1 + AXI_ID_WIDTH;

  logic [C_CMD_W-1:0]      cmd_mem_q [DEPTH];
  logic [C_ORD_W-1:0]      ord_mem_q [DEPTH];
  logic [C_PTR_W-1:0]      cmd_wptr_q, cmd_rptr_q, ord_wptr_q, ord_rptr_q;
  logic                    last_wr_q;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [AXI_ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    w_cmd_empty, w_ord_empty, w_room;
  logic [C_PTR_W-1:0]      w_outstanding;
  logic                    w_wr_req, w_rd_req, w_grant_wr, w_grant_rd, w_accept;
  logic                    w_cmd_pop, w_cpl_ready, w_cpl_fire;
  logic [C_CMD_W-1:0]      w_cmd_in, w_cmd_head;
  logic [C_ORD_W-1:0]      w_ord_in, w_ord_head;
  logic [1:0]              w_resp;

  // The order FIFO holds exactly the outstanding requests, so its fill level is the count
  assign w_cmd_empty   = (cmd_wptr_q == cmd_rptr_q);
  assign w_ord_empty   = (ord_wptr_q == ord_rptr_q);
  assign w_outstanding = ord_wptr_q - ord_rptr_q;
  assign w_room        = (w_outstanding < C_PTR_W'(DEPTH));

  assign w_wr_req   = bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
  assign w_rd_req   = bus.S_AXI_ARVALID;
  assign w_grant_wr = ARESETN & w_room & w_wr_req & (~w_rd_req | ~last_wr_q);
  assign w_grant_rd = ARESETN & w_room & w_rd_req & (~w_wr_req | last_wr_q);
  assign w_accept   = w_grant_wr | w_grant_rd;

  assign w_cmd_in = w_grant_wr ? {1'b1, bus.S_AXI_AWADDR, bus.S_AXI_WDATA, bus.S_AXI_WSTRB}
                               : {1'b0, bus.S_AXI_ARADDR, {DATA_WIDTH{1'b0}}, {C_STRB_W{1'b0}}};
  assign w_ord_in = w_grant_wr ? {1'b1, bus.S_AXI_AWID} : {1'b0, bus.S_AXI_ARID};

  assign w_cmd_head  = cmd_mem_q[cmd_rptr_q[C_IDX_W-1:0]];
  assign w_ord_head  = ord_mem_q[ord_rptr_q[C_IDX_W-1:0]];
  assign w_cmd_pop   = ~w_cmd_empty & bus.cmd_ready;
  assign w_cpl_ready = ~bvalid_q & ~rvalid_q;
  assign w_cpl_fire  = bus.cpl_valid & w_cpl_ready & ~w_ord_empty;
  assign w_resp      = bus.cpl_error ? 2'b10 : 2'b00;

  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      cmd_mem_q[cmd_wptr_q[C_IDX_W-1:0]] <= w_cmd_in;
      ord_mem_q[ord_wptr_q[C_IDX_W-1:0]] <= w_ord_in;
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (bvalid_q && bus.S_AXI_BREADY) bvalid_d = 1'b0;
    if (rvalid_q && bus.S_AXI_RREADY) rvalid_d = 1'b0;
    // A completion only fires with both channels idle, so it never races a clear
    if (w_cpl_fire) begin
      if (w_ord_head[C_ORD_W-1]) begin
        bvalid_d = 1'b1;
        bid_d    = w_ord_head[AXI_ID_WIDTH-1:0];
        bresp_d  = w_resp;
      end else begin
        rvalid_d = 1'b1;
        rid_d    = w_ord_head[AXI_ID_WIDTH-1:0];
        rresp_d  = w_resp;
        rdata_d  = bus.cpl_rdata;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      ord_wptr_q <= '0;
      ord_rptr_q <= '0;
      last_wr_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (w_accept) begin
        cmd_wptr_q <= cmd_wptr_q + C_PTR_W'(1);
        ord_wptr_q <= ord_wptr_q + C_PTR_W'(1);
        last_wr_q  <= w_grant_wr;
      end
      if (w_cmd_pop)  cmd_rptr_q <= cmd_rptr_q + C_PTR_W'(1);
      if (w_cpl_fire) ord_rptr_q <= ord_rptr_q + C_PTR_W'(1);
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.S_AXI_AWREADY = w_grant_wr;
  assign bus.S_AXI_WREADY  = w_grant_wr;
  assign bus.S_AXI_ARREADY = w_grant_rd;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_BID     = bid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.S_AXI_RID     = rid_q;
  assign bus.S_AXI_RRESP   = rresp_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.cpl_ready     = w_cpl_ready;
  assign bus.cmd_valid     = ~w_cmd_empty;
  // Payload is zeroed when empty so the unreset storage never leaks out
  assign {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb} =
      w_cmd_empty ? '0 : w_cmd_head;

endmodule

`default_nettype wire

// File: tb/tb_ddr2_axi_req_queue.sv
//------------------------------------------------------------------------------
// tb_ddr2_axi_req_queue : directed self-checking bench for ddr2_axi_req_queue
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr2_axi_req_queue;

  logic ACLK;
  logic ARESETN;
  int   n_checks;
  int   n_errors;

  ddr2_axi_req_queue_if #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  ddr2_axi_req_queue #(
    .ADDR_WIDTH(28), .DATA_WIDTH(32), .AXI_ID_WIDTH(4), .DEPTH(4)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus.slave)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ARESETN  = 1'b0;
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.cmd_ready = 1'b0; bus.cpl_valid = 1'b0; bus.cpl_rdata = '0; bus.cpl_error = 1'b0;
    // Requests presented during reset must not see READY
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    repeat (2) tick();
    #1;
    chk_val("rst_awready", bus.S_AXI_AWREADY, 0);
    chk_val("rst_wready",  bus.S_AXI_WREADY, 0);
    chk_val("rst_arready", bus.S_AXI_ARREADY, 0);
    chk_val("rst_cmdv",    bus.cmd_valid, 0);
    chk_val("rst_bvalid",  bus.S_AXI_BVALID, 0);
    chk_val("rst_rvalid",  bus.S_AXI_RVALID, 0);
    chk_val("rst_bid",     bus.S_AXI_BID, 0);
    chk_val("rst_rdata",   bus.S_AXI_RDATA, 0);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    tick();
    ARESETN = 1'b1;

    // Completion with nothing outstanding is ignored
    tick();
    bus.cpl_valid = 1'b1;
    #1 chk_val("idle_cplrdy", bus.cpl_ready, 1);
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("idle_bvalid", bus.S_AXI_BVALID, 0);
    chk_val("idle_rvalid", bus.S_AXI_RVALID, 0);

    // Simultaneous write and read: write first after reset, then read
    tick();
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_AWID = 4'd1;
    bus.S_AXI_AWADDR = 28'h0000100; bus.S_AXI_WDATA = 32'h1111_2222; bus.S_AXI_WSTRB = 4'h3;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARID = 4'd2; bus.S_AXI_ARADDR = 28'h0000200;
    #1 chk_val("arb1_awready", bus.S_AXI_AWREADY, 1);
    chk_val("arb1_wready",  bus.S_AXI_WREADY, 1);
    chk_val("arb1_arready", bus.S_AXI_ARREADY, 0);
    tick();
    #1 chk_val("arb2_awready", bus.S_AXI_AWREADY, 0);
    chk_val("arb2_arready", bus.S_AXI_ARREADY, 1);
    chk_val("arb2_cmdv",    bus.cmd_valid, 1);
    chk_val("arb2_cmdw",    bus.cmd_write, 1);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.cmd_ready = 1'b1;
    #1 chk_val("arb_w_addr",  bus.cmd_addr, 28'h0000100);
    chk_val("arb_w_wdata", bus.cmd_wdata, 32'h1111_2222);
    chk_val("arb_w_wstrb", bus.cmd_wstrb, 4'h3);
    tick();
    #1 chk_val("arb_r_cmdv",  bus.cmd_valid, 1);
    chk_val("arb_r_cmdw",  bus.cmd_write, 0);
    chk_val("arb_r_addr",  bus.cmd_addr, 28'h0000200);
    chk_val("arb_r_wdata", bus.cmd_wdata, 0);
    chk_val("arb_r_wstrb", bus.cmd_wstrb, 0);
    tick();
    bus.cmd_ready = 1'b0;
    bus.cpl_valid = 1'b1; bus.cpl_rdata = 32'hDEAD_BEEF; bus.cpl_error = 1'b0;
    #1 chk_val("arb_cmd_empty", bus.cmd_valid, 0);
    tick();
    #1 chk_val("arb_bvalid",  bus.S_AXI_BVALID, 1);
    chk_val("arb_bid",     bus.S_AXI_BID, 1);
    chk_val("arb_bresp",   bus.S_AXI_BRESP, 0);
    chk_val("arb_cplrdy0", bus.cpl_ready, 0);
    chk_val("arb_rvalid0", bus.S_AXI_RVALID, 0);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    #1 chk_val("arb_bclear",  bus.S_AXI_BVALID, 0);
    chk_val("arb_cplrdy1", bus.cpl_ready, 1);
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("arb_rvalid", bus.S_AXI_RVALID, 1);
    chk_val("arb_rid",    bus.S_AXI_RID, 2);
    chk_val("arb_rdata",  bus.S_AXI_RDATA, 32'hDEAD_BEEF);
    chk_val("arb_rresp",  bus.S_AXI_RRESP, 0);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    #1 chk_val("arb_rclear", bus.S_AXI_RVALID, 0);

    // Single write
    tick();
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_AWID = 4'd3;
    bus.S_AXI_AWADDR = 28'h0001000; bus.S_AXI_WDATA = 32'hA5A5_1234; bus.S_AXI_WSTRB = 4'hF;
    #1 chk_val("w1_awready", bus.S_AXI_AWREADY, 1);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    #1 chk_val("w1_cmdv",  bus.cmd_valid, 1);
    chk_val("w1_cmdw",  bus.cmd_write, 1);
    chk_val("w1_addr",  bus.cmd_addr, 28'h0001000);
    chk_val("w1_wdata", bus.cmd_wdata, 32'hA5A5_1234);
    chk_val("w1_wstrb", bus.cmd_wstrb, 4'hF);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0; bus.cpl_valid = 1'b1; bus.cpl_error = 1'b0;
    #1 chk_val("w1_cmd_pop", bus.cmd_valid, 0);
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("w1_bvalid", bus.S_AXI_BVALID, 1);
    chk_val("w1_bid",    bus.S_AXI_BID, 3);
    chk_val("w1_bresp",  bus.S_AXI_BRESP, 0);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;

    // Fill to DEPTH with reads, then free one slot via completion
    for (int i = 0; i < 4; i++) begin
      bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARID = 4'(i); bus.S_AXI_ARADDR = 28'(i * 256);
      #1 chk_val($sformatf("fill%0d_arready", i), bus.S_AXI_ARREADY, 1);
      tick();
    end
    bus.S_AXI_ARID = 4'd4; bus.S_AXI_ARADDR = 28'h0000400;
    #1 chk_val("full_arready", bus.S_AXI_ARREADY, 0);
    chk_val("full_head_addr", bus.cmd_addr, 0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    #1 chk_val("full_arready_pop", bus.S_AXI_ARREADY, 0);
    chk_val("full_head_addr1", bus.cmd_addr, 28'h0000100);
    bus.cpl_valid = 1'b1; bus.cpl_rdata = 32'h0000_0055;
    #1 chk_val("full_arready_cpl", bus.S_AXI_ARREADY, 0);
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("fifth_arready", bus.S_AXI_ARREADY, 1);
    chk_val("fill_rvalid", bus.S_AXI_RVALID, 1);
    chk_val("fill_rid",    bus.S_AXI_RID, 0);
    chk_val("fill_rdata",  bus.S_AXI_RDATA, 32'h0000_0055);
    tick();
    #1 chk_val("refull_arready", bus.S_AXI_ARREADY, 0);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;

    // Error completion on read, response stalled by RREADY low
    bus.cpl_valid = 1'b1; bus.cpl_error = 1'b1; bus.cpl_rdata = 32'h1234_5678;
    tick();
    bus.cpl_error = 1'b0; bus.cpl_rdata = 32'h0BAD_F00D;
    #1 chk_val("err_rvalid", bus.S_AXI_RVALID, 1);
    chk_val("err_rresp",  bus.S_AXI_RRESP, 2'b10);
    chk_val("err_rid",    bus.S_AXI_RID, 1);
    chk_val("err_rdata",  bus.S_AXI_RDATA, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk_val($sformatf("stall%0d_rvalid", i), bus.S_AXI_RVALID, 1);
      chk_val($sformatf("stall%0d_cplrdy", i), bus.cpl_ready, 0);
      chk_val($sformatf("stall%0d_rdata", i), bus.S_AXI_RDATA, 32'h1234_5678);
      chk_val($sformatf("stall%0d_rresp", i), bus.S_AXI_RRESP, 2'b10);
    end
    bus.cpl_valid = 1'b0; bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    #1 chk_val("err_rclear", bus.S_AXI_RVALID, 0);

    // Drain remaining reads (IDs 2,3,4) in order
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cpl_valid = 1'b1;
      tick();
      bus.cpl_valid = 1'b0;
      #1 chk_val($sformatf("drain%0d_rid", i), bus.S_AXI_RID, 4'(i + 2));
      bus.S_AXI_RREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0;
    end
    bus.cmd_ready = 1'b0;
    #1 chk_val("drain_cmdv", bus.cmd_valid, 0);

    // Reset with 3 outstanding and BVALID high
    tick();
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_AWID = 4'd6;
    bus.S_AXI_AWADDR = 28'h0002000; bus.S_AXI_WDATA = 32'h6666_0000; bus.S_AXI_WSTRB = 4'hF;
    #1 chk_val("pre_awready", bus.S_AXI_AWREADY, 1);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARID = 4'd7; bus.S_AXI_ARADDR = 28'h0003000;
    for (int i = 0; i < 3; i++) begin
      #1 chk_val($sformatf("pre%0d_arready", i), bus.S_AXI_ARREADY, 1);
      tick();
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.cpl_valid = 1'b1;
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("pre_bvalid", bus.S_AXI_BVALID, 1);
    chk_val("pre_bid",    bus.S_AXI_BID, 6);
    ARESETN = 1'b0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1 chk_val("mid_bvalid",  bus.S_AXI_BVALID, 0);
    chk_val("mid_bid",     bus.S_AXI_BID, 0);
    chk_val("mid_cmdv",    bus.cmd_valid, 0);
    chk_val("mid_cmdaddr", bus.cmd_addr, 0);
    chk_val("mid_awready", bus.S_AXI_AWREADY, 0);
    chk_val("mid_arready", bus.S_AXI_ARREADY, 0);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    ARESETN = 1'b1;
    #1 chk_val("post_cmdv",   bus.cmd_valid, 0);
    chk_val("post_bvalid", bus.S_AXI_BVALID, 0);
    tick();
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_AWID = 4'd9;
    bus.S_AXI_AWADDR = 28'h000003C; bus.S_AXI_WDATA = 32'hCAFE_0009; bus.S_AXI_WSTRB = 4'h5;
    #1 chk_val("post_awready", bus.S_AXI_AWREADY, 1);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    #1 chk_val("post_cmdv1",  bus.cmd_valid, 1);
    chk_val("post_addr",   bus.cmd_addr, 28'h000003C);
    chk_val("post_wstrb",  bus.cmd_wstrb, 4'h5);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0; bus.cpl_valid = 1'b1;
    tick();
    bus.cpl_valid = 1'b0;
    #1 chk_val("post_bvalid1", bus.S_AXI_BVALID, 1);
    chk_val("post_bid",     bus.S_AXI_BID, 9);
    chk_val("post_bresp",   bus.S_AXI_BRESP, 0);
    chk_val("post_rvalid",  bus.S_AXI_RVALID, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
